// File: rtl/div_unit_if.sv
// Issue/result bundle between the EX-stage control (master) and div_unit (slave).
// DIV_ZERO_FLAG_EN adds the div_zero flag to the bundle.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic [7:0]         alucontrol;
  logic               start;
  logic               annul;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               ready;
  logic [2*WIDTH-1:0] result;
`ifdef DIV_ZERO_FLAG_EN
  logic               div_zero;
`endif

  // start is a request that div_unit accepts only in IDLE: it is dropped, never
  // queued, while busy=1 or ready=1. ready is a one-cycle pulse marking result
  // valid. annul aborts the op in flight and wins over start in the same cycle.
  modport master (
    output alucontrol, start, annul, a, b,
`ifdef DIV_ZERO_FLAG_EN
    input  div_zero,
`endif
    input  busy, ready, result
  );

  modport slave (
    input  alucontrol, start, annul, a, b,
`ifdef DIV_ZERO_FLAG_EN
    output div_zero,
`endif
    output busy, ready, result
  );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle, then a sign fix-up.
// Optional DIV_ZERO_FLAG_EN adds a registered divide-by-zero flag next to result.
module div_unit #(
  parameter int         WIDTH   = 32,
  parameter logic [7:0] DIV_OP  = 8'b00011010,
  parameter logic [7:0] DIVU_OP = 8'b00011011
) (
  input  logic        clk,
  input  logic        rst,
  div_unit_if.slave   bus,
  output logic [1:0]  dbg_state_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [CW-1:0]      count_q, count_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               div_zero_q, div_zero_d;

  logic               op_hit;
  logic               op_signed;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     shifted, diff;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Operand decode and magnitudes; abs(most-negative) wraps to itself and is
  // then treated as an unsigned magnitude.
  always_comb begin
    op_signed = (bus.alucontrol == DIV_OP);
    op_hit    = bus.start && ((bus.alucontrol == DIV_OP) || (bus.alucontrol == DIVU_OP));
    a_neg     = op_signed && bus.a[WIDTH-1];
    b_neg     = op_signed && bus.b[WIDTH-1];
    a_mag     = a_neg ? (-bus.a) : bus.a;
    b_mag     = b_neg ? (-bus.b) : bus.b;
  end

  // One restoring step: the shifted partial remainder needs WIDTH+1 bits, and
  // the MSB of the difference tells whether the subtraction went negative.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, divisor_q};
    quo_fix = neg_quo_q ? (-quo_q) : quo_q;
    rem_fix = neg_rem_q ? (-rem_q) : rem_q;
  end

  always_comb begin
    state_d    = state_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    count_d    = count_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    div_zero_d = div_zero_q;

    if (bus.annul) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (op_hit) begin
            if (bus.b == '0) begin
              state_d    = S_DONE;
              result_d   = {bus.a, {WIDTH{1'b1}}};
              div_zero_d = 1'b1;
            end else begin
              state_d    = S_BUSY;
              divisor_d  = b_mag;
              rem_d      = '0;
              quo_d      = a_mag;
              count_d    = '0;
              neg_quo_d  = a_neg ^ b_neg;
              neg_rem_d  = a_neg;
            end
          end
        end
        S_BUSY: begin
          if (!diff[WIDTH]) begin
            rem_d = diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          count_d = count_q + CW'(1);
          if (count_q == LAST_STEP) begin
            state_d = S_SIGN;
          end
        end
        S_SIGN: begin
          state_d    = S_DONE;
          result_d   = {rem_fix, quo_fix};
          div_zero_d = 1'b0;
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d  = (state_d == S_BUSY) || (state_d == S_SIGN);
    ready_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      divisor_q  <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      count_q    <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      count_q    <= count_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      result_q   <= result_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.ready   = ready_q;
  assign bus.result  = result_q;
  assign dbg_state_o = state_q;

`ifdef DIV_ZERO_FLAG_EN
  assign bus.div_zero = div_zero_q;
`else
  logic unused_div_zero;
  assign unused_div_zero = div_zero_q;
`endif

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed corner cases plus random DIV/DIVU ops against an arithmetic model.
// Build with DIV_ZERO_FLAG_EN defined to also check the div_zero flag.
module tb_div_unit;
  localparam int W = 32;
  localparam logic [7:0] DIV_OP  = 8'b00011010;
  localparam logic [7:0] DIVU_OP = 8'b00011011;
  localparam logic [7:0] ADDI_OP = 8'b00100000;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  div_unit_if #(.WIDTH(W)) bus ();

  div_unit #(.WIDTH(W), .DIV_OP(DIV_OP), .DIVU_OP(DIVU_OP)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_result;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, {hi=remainder, lo=quotient}.
  function automatic logic [2*W-1:0] model(input logic [7:0] op, input logic [W-1:0] av,
                                           input logic [W-1:0] bv);
    int sa, sb, q, r;
    if (bv == 0) return {av, 32'hFFFF_FFFF};
    if (op == DIVU_OP) return {av % bv, av / bv};
    if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = av;
    sb = bv;
    q  = sa / sb;
    r  = sa % sb;
    return {r, q};
  endfunction

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op and follow it to its ready pulse. poke>=0 fires a stray
  // start in that cycle of the busy window, which must be ignored.
  task automatic run_op(input string tag, input logic [7:0] op, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input int poke);
    int k;
    bit got, gap;
    int exp_lat;
    exp_q.push_back(model(op, av, bv));
    exp_lat = (bv == 0) ? 0 : 33;
    @(negedge clk);
    bus.alucontrol = op; bus.a = av; bus.b = bv; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
    k = 0; got = 0; gap = 0;
    while (k < 60 && !got) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.ready) begin
        got = 1;
      end else begin
        if (!bus.busy) gap = 1;
        if (k == poke) begin
          bus.alucontrol = DIV_OP; bus.a = 32'd99; bus.b = 32'd3; bus.start = 1'b1;
        end
        k++;
      end
    end
    check_eq({tag, "_latency"}, 64'(k), 64'(exp_lat));
    check_eq({tag, "_busy_hold"}, 64'(gap), 64'(0));
    if (got) begin
      last_result = exp_q.pop_front();
      check_eq({tag, "_result"}, bus.result, last_result);
      check_eq({tag, "_busy_at_ready"}, 64'(bus.busy), 64'(0));
`ifdef DIV_ZERO_FLAG_EN
      check_eq({tag, "_div_zero"}, 64'(bus.div_zero), 64'(bv == 0));
`endif
      @(negedge clk);
      check_eq({tag, "_ready_pulse"}, 64'(bus.ready), 64'(0));
    end else begin
      void'(exp_q.pop_front());
    end
  endtask

  // Watch n cycles expecting neither busy nor ready, and result unchanged.
  task automatic watch_quiet(input string tag, input int n, input logic [2*W-1:0] keep);
    int hits;
    hits = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.busy || bus.ready) hits++;
    end
    check_eq({tag, "_quiet"}, 64'(hits), 64'(0));
    check_eq({tag, "_result_kept"}, bus.result, keep);
  endtask

  initial begin
    int k;
    bus.alucontrol = '0; bus.start = 1'b0; bus.annul = 1'b0; bus.a = '0; bus.b = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 64'(bus.busy), 64'(0));
    check_eq("rst_ready", 64'(bus.ready), 64'(0));
    check_eq("rst_result", bus.result, 64'(0));
    rst = 1'b1;
    @(negedge clk);

    run_op("t1_divu", DIVU_OP, 32'd100, 32'd7, -1);
    run_op("t2_div_neg", DIV_OP, 32'hFFFF_FFF9, 32'd2, -1);
    run_op("t3_ovf", DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_op("t4_div0", DIVU_OP, 32'h0000_1234, 32'h0, -1);
    run_op("t4_div0_s", DIV_OP, 32'h8000_0001, 32'h0, -1);
    run_op("divu_max", DIVU_OP, 32'hFFFF_FFFF, 32'h8000_0000, -1);
    run_op("div_mn_pos", DIV_OP, 32'h8000_0000, 32'd1, -1);

    // stray start during busy is dropped
    run_op("t6_poke", DIVU_OP, 32'd1000, 32'd10, 5);
    watch_quiet("t6_after_poke", 40, last_result);

    // non-divide opcode, and annul beating start
    @(negedge clk);
    bus.alucontrol = ADDI_OP; bus.a = 32'd9; bus.b = 32'd3; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    watch_quiet("t6_addi", 40, last_result);
    @(negedge clk);
    bus.alucontrol = DIV_OP; bus.start = 1'b1; bus.annul = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.annul = 1'b0;
    watch_quiet("annul_vs_start", 40, last_result);

    // annul in flight
    @(negedge clk);
    bus.alucontrol = DIV_OP; bus.a = 32'd500; bus.b = 32'd7; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (k = 0; k < 10; k++) @(negedge clk);
    bus.annul = 1'b1;
    @(negedge clk);
    bus.annul = 1'b0;
    check_eq("t5_annul_busy", 64'(bus.busy), 64'(0));
    watch_quiet("t5_annul", 40, last_result);

    // random ops
    for (int i = 0; i < 24; i++) begin
      logic [7:0] op;
      op = $urandom_range(0, 1) ? DIV_OP : DIVU_OP;
      run_op($sformatf("rnd%0d", i), op, pick_val(), pick_val(), -1);
    end

    // reset mid-operation
    @(negedge clk);
    bus.alucontrol = DIVU_OP; bus.a = 32'd77; bus.b = 32'd5; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("t5_rst_busy", 64'(bus.busy), 64'(0));
    check_eq("t5_rst_ready", 64'(bus.ready), 64'(0));
    check_eq("t5_rst_result", bus.result, 64'(0));
    @(negedge clk);
    rst = 1'b1;
    watch_quiet("t5_rst_after", 40, 64'(0));
    run_op("post_rst", DIV_OP, 32'hFFFF_FF9C, 32'hFFFF_FFF9, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
